// File: rtl/add1_pkg.sv
// -----------------------------------------------------------------------------
// add1_pkg
// Shared types and constants for the add_1 full-adder cell.
//   CNT_W_DEFAULT : default width of the optional carry-event counter
//   add1_res_t    : packed {sum, carry} pair held by the registered path
// -----------------------------------------------------------------------------
package add1_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef struct packed {
        logic sum;
        logic carry;
    } add1_res_t;

endpackage : add1_pkg

// File: rtl/add_1_half_add.sv
// -----------------------------------------------------------------------------
// half_add
// Combinational half adder, the building cell of add_1.
// Ports:
//   a, b : input bits
//   s    : sum   = a ^ b
//   c    : carry = a & b
// -----------------------------------------------------------------------------
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule : half_add

// File: rtl/add_1.sv
// -----------------------------------------------------------------------------
// add_1
// 1-bit full adder for ripple-carry chains, with a registered copy of the
// result for pipelined consumers.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous, active-high reset
//   a, b       : addend bits
//   carry_in   : carry from the less-significant stage
//   in_valid   : capture strobe for the registered path
//   out        : combinational sum   (a ^ b ^ carry_in)
//   carry_out  : combinational carry ((a & b) | (carry_in & (a ^ b)))
//   out_q      : registered sum
//   carry_q    : registered carry
//   out_valid  : one-cycle pulse following each accepted in_valid
//   carry_cnt  : saturating count of captures with carry_out = 1
//                (present only when ADD1_CARRY_CNT_EN is defined)
//
// Configuration macro: ADD1_CARRY_CNT_EN enables the carry_cnt port/counter.
//
// Handshake: in_valid is sampled on every rising clk edge and is always
// accepted (there is no ready/backpressure). An accepted input appears on
// out_q/carry_q with out_valid=1 exactly one cycle later; when in_valid is
// low, out_valid drops and out_q/carry_q keep their last captured values.
// -----------------------------------------------------------------------------
module add_1
    import add1_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             carry_in,
    input  logic             in_valid,
    output logic             out,
    output logic             carry_out,
    output logic             out_q,
    output logic             carry_q,
    output logic             out_valid
`ifdef ADD1_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Elaboration-time guard on the counter width.
    if (CNT_W < 2 || CNT_W > 32) begin : g_cnt_w_check
        $error("add_1: CNT_W must be in 2..32");
    end

    // ------------------------------------------------------------------
    // Combinational full adder from two half adders. No clock or reset
    // involvement, so chained stages ripple within a single cycle.
    // ------------------------------------------------------------------
    logic s0, c0, c1;

    half_add u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_add u_ha1 (
        .a (s0),
        .b (carry_in),
        .s (out),
        .c (c1)
    );

    // c0 and c1 are never both 1, so OR is the exact carry.
    assign carry_out = c0 | c1;

    // ------------------------------------------------------------------
    // Registered path
    // ------------------------------------------------------------------
    add1_res_t res_q, res_d;
    logic      valid_q, valid_d;

    always_comb begin
        res_d   = res_q;
        valid_d = in_valid;
        if (in_valid) begin
            res_d.sum   = out;
            res_d.carry = carry_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign out_q     = res_q.sum;
    assign carry_q   = res_q.carry;
    assign out_valid = valid_q;

`ifdef ADD1_CARRY_CNT_EN
    // ------------------------------------------------------------------
    // Saturating carry-event counter: counts accepted inputs that
    // produce a carry, sticking at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (in_valid && carry_out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule : add_1

// File: tb/tb_add_1.sv
// -----------------------------------------------------------------------------
// tb_add_1
// Self-checking bench for add_1: truth-table vectors, directed multi-cycle
// sequences for the registered path and reset, and a randomized run compared
// against an arithmetic reference model. The counter sequence runs only when
// ADD1_CARRY_CNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_add_1;

    localparam int CNT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic a, b, carry_in, in_valid;
    logic out, carry_out, out_q, carry_q, out_valid;
`ifdef ADD1_CARRY_CNT_EN
    logic [CNT_W-1:0] carry_cnt;
`endif

    add_1 #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .in_valid  (in_valid),
        .out       (out),
        .carry_out (carry_out),
        .out_q     (out_q),
        .carry_q   (carry_q),
        .out_valid (out_valid)
`ifdef ADD1_CARRY_CNT_EN
        ,
        .carry_cnt (carry_cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ai, input logic bi, input logic ci, input logic vi);
        a        = ai;
        b        = bi;
        carry_in = ci;
        in_valid = vi;
    endtask

    // Apply inputs at the falling edge, then step to just past the rising edge.
    task automatic cycle(input logic ai, input logic bi, input logic ci, input logic vi);
        @(negedge clk);
        drive(ai, bi, ci, vi);
        @(posedge clk);
        #1;
    endtask

    // ---------------- truth table ----------------
    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_out;
        logic exp_cout;
    } vec_t;

    vec_t tbl[8];

    // ---------------- reference model state ----------------
    logic [1:0] m_res;   // {sum, carry} last captured
    int         m_cnt;
    logic [1:0] ref_sum;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // ---- reset state ----
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #12;
        check("reset_out_q", 32'(out_q), 0);
        check("reset_carry_q", 32'(carry_q), 0);
        check("reset_out_valid", 32'(out_valid), 0);
`ifdef ADD1_CARRY_CNT_EN
        check("reset_carry_cnt", 32'(carry_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ---- 1. exhaustive combinational sweep ----
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
            #10;
            check($sformatf("comb_out_%0d", i), 32'(out), 32'(tbl[i].exp_out));
            check($sformatf("comb_cout_%0d", i), 32'(carry_out), 32'(tbl[i].exp_cout));
        end

        // ---- 2. registered path, single capture then hold ----
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check("reg_out_q", 32'(out_q), 0);
        check("reg_carry_q", 32'(carry_q), 1);
        check("reg_out_valid", 32'(out_valid), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_out_valid", 32'(out_valid), 0);
        check("hold_out_q", 32'(out_q), 0);
        check("hold_carry_q", 32'(carry_q), 1);

        // ---- 3. reset mid-operation ----
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("pre_rst_out_q", 32'(out_q), 1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_out_q", 32'(out_q), 0);
        check("rst_mid_carry_q", 32'(carry_q), 0);
        check("rst_mid_out_valid", 32'(out_valid), 0);
        check("rst_comb_out", 32'(out), 1);
        check("rst_comb_cout", 32'(carry_out), 0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("rst_comb_out_111", 32'(out), 1);
        check("rst_comb_cout_111", 32'(carry_out), 1);
        @(posedge clk);
        #1;
        check("rst_edge_out_valid", 32'(out_valid), 0);
        check("rst_edge_out_q", 32'(out_q), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("post_rst_idle_valid", 32'(out_valid), 0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        check("post_rst_cap_valid", 32'(out_valid), 1);
        check("post_rst_cap_out_q", 32'(out_q), 1);

        // ---- 4. back-to-back captures ----
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check("b2b0_valid", 32'(out_valid), 1);
        check("b2b0_res", 32'({out_q, carry_q}), 32'b01);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("b2b1_valid", 32'(out_valid), 1);
        check("b2b1_res", 32'({out_q, carry_q}), 32'b10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("b2b2_valid", 32'(out_valid), 1);
        check("b2b2_res", 32'({out_q, carry_q}), 32'b00);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b_end_valid", 32'(out_valid), 0);

`ifdef ADD1_CARRY_CNT_EN
        // ---- 5. saturating counter ----
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
            check($sformatf("cnt_%0d", i), 32'(carry_cnt), (i < 3) ? i + 1 : 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("cnt_rst", 32'(carry_cnt), 0);
        rst = 1'b0;
`endif

        // ---- randomized run against arithmetic model ----
        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        m_res = 2'b00;
        m_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) begin
                rst = 1'b1;
                #1;
                m_res = 2'b00;
                m_cnt = 0;
                exp_q.delete();
                check("rnd_rst_valid", 32'(out_valid), 0);
                rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            // sum of three bits: bit0 is the sum, bit1 the carry
            ref_sum = 2'(int'(a) + int'(b) + int'(carry_in));
            check("rnd_comb_out", 32'(out), 32'(ref_sum[0]));
            check("rnd_comb_cout", 32'(carry_out), 32'(ref_sum[1]));
            if (in_valid) begin
                exp_q.push_back({ref_sum[0], ref_sum[1]});
                if (ref_sum[1] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            @(posedge clk);
            #1;
            check("rnd_out_valid", 32'(out_valid), 32'(in_valid));
            if (exp_q.size() > 0) m_res = exp_q.pop_front();
            check("rnd_res", 32'({out_q, carry_q}), 32'(m_res));
`ifdef ADD1_CARRY_CNT_EN
            check("rnd_cnt", 32'(carry_cnt), m_cnt);
`endif
        end

        // ---- report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_add_1
